// File: rtl/imem_load_ctrl.sv
// Instruction memory load controller: clears the array, loads a little-endian
// byte stream as 32-bit words, and serves zero-latency CPU fetches when idle.
module imem_load_ctrl #(
  parameter int unsigned DEPTH  = 1000,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              load_start,
  input  logic [15:0]       load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       cpu_PC,
  output logic [31:0]       cpu_instr,
  output logic              cpu_fault,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              load_busy,
  output logic              load_done
);

  localparam int unsigned LEN_W    = 16;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  // The word index must be able to reach every array entry
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
    $error("imem_load_ctrl: 2**ADDR_W must be >= DEPTH");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         word_q, word_d;

  logic fault_c;
  logic clear_last_c;
  logic write_last_c;
  logic byte_xfer_c;

  assign fault_c      = (cpu_PC[1:0] != 2'b00) || ({2'b00, cpu_PC[31:2]} >= DEPTH);
  assign clear_last_c = (wr_ptr_q == LAST_IDX);
  assign write_last_c = (32'(wr_ptr_q) == (32'(len_q) - 32'd1));
  assign byte_xfer_c  = (state_q == ST_RECV) && byte_valid;

  // State register
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_start) state_d = ST_CLEAR;
      ST_CLEAR: if (clear_last_c) state_d = (len_q != '0) ? ST_RECV : ST_DONE;
      ST_RECV:  if (byte_valid && (byte_cnt_q == 2'd3)) state_d = ST_WRITE;
      ST_WRITE: state_d = write_last_c ? ST_DONE : ST_RECV;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: length, write pointer, byte counter, packed word
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      len_q      <= '0;
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  // Datapath next-state: latch length, walk pointer, pack bytes little-endian
  always_comb begin
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          len_d      = ({16'b0, load_len} > DEPTH) ? LEN_W'(DEPTH) : load_len;
          wr_ptr_d   = '0;
          byte_cnt_d = '0;
        end
      end
      ST_CLEAR: wr_ptr_d = clear_last_c ? '0 : wr_ptr_q + ADDR_W'(1);
      ST_WRITE: if (!write_last_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      default: ;
    endcase
    if (byte_xfer_c) begin
      case (byte_cnt_q)
        2'd0:    word_d[7:0]   = byte_data;
        2'd1:    word_d[15:8]  = byte_data;
        2'd2:    word_d[23:16] = byte_data;
        default: word_d[31:24] = byte_data;
      endcase
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  // Output decode: memory port, loader handshake, CPU fetch path
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_addr   = wr_ptr_q;
    cpu_hold   = 1'b1;
    cpu_instr  = NOP;
    cpu_fault  = 1'b0;
    load_busy  = 1'b1;
    load_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_busy = 1'b0;
        cpu_hold  = 1'b0;
        mem_addr  = cpu_PC[ADDR_W+1:2];
        cpu_fault = fault_c;
        cpu_instr = fault_c ? NOP : mem_rdata;
      end
      ST_CLEAR: mem_we = 1'b1;
      ST_RECV:  byte_ready = 1'b1;
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = word_q;
      end
      ST_DONE:  load_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter DEPTH, default 1000, number of 32-bit words in the instruction memory array.
REQ-002 Parameter ADDR_W, default 10, width of the word index; the block SHALL require 2**ADDR_W >= DEPTH.
REQ-003 SYS_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 SYS_reset  in  1  asynchronous, active-low reset.
REQ-005 load_start  in  1  one-cycle request to begin a program load.
REQ-006 load_len  in  16  number of words to load, sampled when load_start is accepted.
REQ-007 byte_valid  in  1  loader byte is present.
REQ-008 byte_data  in  8  loader byte.
REQ-009 byte_ready  out  1  block accepts byte_data this cycle.
REQ-010 cpu_PC  in  32  fetch byte address.
REQ-011 cpu_instr  out  32  fetched instruction.
REQ-012 cpu_fault  out  1  fetch address misaligned or out of range.
REQ-013 cpu_hold  out  1  CPU SHALL stall while high.
REQ-014 mem_addr  out  ADDR_W  word index to the memory array.
REQ-015 mem_we  out  1  write strobe, written on the SYS_clk edge.
REQ-016 mem_wdata  out  32  write data.
REQ-017 mem_rdata  in  32  combinational read data for mem_addr.
REQ-018 load_busy  out  1  high in any state except IDLE; load_done  out  1  one-cycle completion pulse.

Function
REQ-019 States: IDLE, CLEAR, RECV, WRITE, DONE.
REQ-020 IDLE + load_start -> CLEAR. The block SHALL latch len_q = min(load_len, DEPTH) and set wr_ptr = 0.
REQ-021 load_start outside IDLE SHALL be ignored.
REQ-022 CLEAR SHALL write 0 to index wr_ptr with mem_we=1 each cycle, wr_ptr 0..DEPTH-1.
REQ-023 CLEAR exit after index DEPTH-1: wr_ptr SHALL become 0; next state RECV if len_q > 0, else DONE.
REQ-024 RECV: byte_ready = 1; a byte SHALL transfer only when byte_valid and byte_ready are both high.
REQ-025 Byte packing is little-endian: byte k (k = 0..3) of the word SHALL go to bits [8k+7:8k]; a 2-bit byte counter SHALL wrap 3 -> 0.
REQ-026 Fourth byte transferred -> WRITE.
REQ-027 WRITE lasts exactly one cycle: byte_ready = 0, mem_we = 1, mem_addr = wr_ptr, mem_wdata = packed word.
REQ-028 WRITE exit: if wr_ptr == len_q-1 -> DONE; else wr_ptr increments and next state is RECV.
REQ-029 DONE lasts one cycle with load_done = 1, then -> IDLE.
REQ-030 IDLE fetch: mem_addr = cpu_PC[ADDR_W+1:2], mem_we = 0, and cpu_instr SHALL equal mem_rdata combinationally (zero latency).
REQ-031 cpu_fault = 1 when cpu_PC[1:0] != 0 or cpu_PC[31:2] >= DEPTH; in that case cpu_instr SHALL be 32'h00000013 (NOP).
REQ-032 Outside IDLE: cpu_hold = 1, cpu_instr = 32'h00000013, cpu_fault = 0.
REQ-033 mem_we SHALL never assert in IDLE or DONE.
REQ-034 byte_valid outside RECV SHALL be ignored; no byte is consumed.

Reset
REQ-035 SYS_reset low SHALL immediately force IDLE, wr_ptr = 0, byte counter = 0, packed word = 0, and load_done = 0, independent of SYS_clk.
REQ-036 A reset during CLEAR, RECV or WRITE SHALL abort the load; partially written contents are left as-is and no load_done pulse is produced.
REQ-037 After reset release: byte_ready = 0, mem_we = 0, load_busy = 0, cpu_hold = 0.

Verification
REQ-038 Reset, then cpu_PC = 0x8 with memory word 2 = 0x00500093 -> same cycle cpu_instr = 0x00500093, cpu_fault = 0, cpu_hold = 0.
REQ-039 load_start with load_len = 2, bytes 93,00,50,00,13,01,A0,00 -> DEPTH CLEAR writes of 0, then word0 = 0x00500093, word1 = 0x00A00113, one load_done pulse, return to IDLE.
REQ-040 Same load with byte_valid toggled every other cycle -> identical memory contents; byte_ready low during the two WRITE cycles.
REQ-041 load_len = 0 -> CLEAR only, then load_done; load_len = 2000 -> exactly DEPTH word writes after CLEAR.
REQ-042 cpu_PC = 0x6 -> cpu_fault = 1, cpu_instr = 0x00000013; cpu_PC = 4*DEPTH -> cpu_fault = 1.
REQ-043 SYS_reset asserted after 5 bytes of a load, then a second load_start after release -> state IDLE immediately on reset, no load_done; the second load completes normally.
